sync_edge_event: RTL and testbench
==================================

# sync_edge_event

Downstream consumer of the multi-flop synchronizer output in the `dst_clk` domain. Takes the already-synchronized `sync_data` level, applies a consecutive-sample glitch filter, and emits single-cycle rise/fall pulses. Each accepted edge is logged with a timestamp into a small event FIFO, drained through a valid/ready handshake. Rising edges are also counted, and a sticky overflow flag marks dropped events.

## Interface
- `FILTER_LEN`, 3: consecutive mismatching samples required to accept a level change; legal range 1..255.
- `TS_W`, 16: timestamp counter width.
- `FIFO_DEPTH`, 4: event FIFO entries; power of 2, ≥2.
- `CNT_W`, 8: rising-edge counter width.

Ports:
- `dst_clk` in 1: sole clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sync_data` in 1: synchronized level from the multi-flop synchronizer.
- `filt_data` out 1: filtered level.
- `rise_pulse` out 1: one-cycle pulse on an accepted 0→1.
- `fall_pulse` out 1: one-cycle pulse on an accepted 1→0.
- `evt_valid` out 1: FIFO head valid.
- `evt_ready` in 1: consumer accepts head.
- `evt_rising` out 1: head event type, 1 = rising, 0 = falling.
- `evt_ts` out TS_W: head event timestamp.
- `rise_count` out CNT_W: saturating count of accepted rising edges.
- `overflow` out 1: sticky; an event was dropped on a full FIFO.
- `clr_overflow` in 1: clears `overflow` (synchronous).

## Operation
- **Reset:** all outputs 0; `filt_data`=0; filter count, timestamp, FIFO pointers and `rise_count` are 0.
- **Timestamp:** `ts_cnt` is 0 in the first cycle after reset release, increments by 1 every cycle, and wraps from 2^TS_W−1 to 0.
- **Filter counter `m`:**
  - On each edge with `sync_data != filt_data`, `m` increments.
  - On the edge where this is the FILTER_LEN-th consecutive mismatch, `filt_data <= sync_data` and `m <= 0` (the accepting edge).
  - Any edge with `sync_data == filt_data` sets `m <= 0`.
  - FILTER_LEN=1 means no filtering.
- **Accepting edge:**
  - `rise_pulse` or `fall_pulse` is high for exactly the following cycle.
  - An event {type, `ts_cnt` current value} is pushed.
  - On a rising edge, `rise_count` increments unless it is at 2^CNT_W−1, where it holds.
  - `rise_count` counts every accepted edge, including events dropped on a full FIFO.
- **FIFO:**
  - Pop occurs on an edge with `evt_valid && evt_ready`.
  - Push when not full, or when full with a pop on the same edge; simultaneous push+pop keeps occupancy unchanged.
  - Push on full with no pop drops the event and sets `overflow`.
  - When empty, `evt_valid`=0 and `evt_rising`/`evt_ts` are driven to 0.
  - `evt_rising`/`evt_ts` hold stable while `evt_valid && !evt_ready`.
- **Overflow flag:**
  - `clr_overflow` clears `overflow`.
  - If a clear and a new drop occur on the same edge, the set wins.
- **Reset mid-operation:** FIFO contents are discarded and an in-progress filter count is lost; there is no pulse on the reset edge.

## Timing
- Latency: if `sync_data` changes before edge k and holds, `filt_data` and the pulse are visible after edge k+FILTER_LEN−1. `evt_valid` rises on that same edge if the FIFO was empty.
- Recorded `evt_ts` = `ts_cnt` value in the cycle before the accepting edge.
- Handshake has no combinational path from `evt_ready` to `evt_valid`; outputs are registered.
- Minimum spacing between accepted edges is FILTER_LEN cycles.

## Structure
- Package `cdc_pkg`: event record layout (rising bit + TS_W timestamp), and localparam for the pointer width `$clog2(FIFO_DEPTH)`.
- Sub-module `evt_fifo`: synchronous FIFO with push/pop/full/empty and registered head. Filter, pulse, counter and timestamp logic stay in the top.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `sync_data`=1 → all outputs 0; after release with `sync_data`=1 held, `filt_data`=1 after the 3rd edge, one `rise_pulse`, event {1, ts=2}.
- **Glitch filter:** FILTER_LEN=3, `sync_data` high for 2 cycles then low → `filt_data` stays 0, no pulse, no event, `rise_count`=0.
- **Full toggle sequence:** rise then fall 10 cycles apart, `evt_ready`=1 → two events in order: rising then falling, timestamps differ by 10; `rise_count`=1.
- **Overflow:** `evt_ready`=0 and 5 accepted edges with FIFO_DEPTH=4 → 4 events stored, 5th dropped, `overflow`=1.
  - Then pulse `clr_overflow` → `overflow`=0.
  - Then drain → the 4 original events in order.
- **Full with simultaneous push and pop:** FIFO full, accepted edge coincides with `evt_ready`=1 → no drop, occupancy stays 4, `overflow` stays 0.
- **Saturation and wrap:** CNT_W=2, 5 rising edges → `rise_count`=3. TS_W=4, run 20 cycles → `ts_cnt` wraps and the event timestamps reflect modulo-16 values.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the synchronized edge-event logger.
package cdc_pkg;

    // Default configuration values. Instances may override them.
    localparam int TS_W_DEF       = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int PTR_W_DEF      = $clog2(FIFO_DEPTH_DEF);

    // Event record layout: the type bit sits above the timestamp.
    typedef struct packed {
        logic                rising;
        logic [TS_W_DEF-1:0] ts;
    } evt_t;

    // Width of a packed event record for a given timestamp width.
    function automatic int evt_width(input int ts_w);
        return ts_w + 1;
    endfunction

    // Pointer width for a power-of-two FIFO depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous event FIFO. The head is held in registers, so o_valid and
// o_data have no combinational path from i_ready.
module evt_fifo
    import cdc_pkg::*;
#(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full
);
    localparam int              PTR_W     = ptr_width(DEPTH);
    localparam int              CNT_W     = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;
    logic [DATA_W-1:0] r_head;

    logic              w_pop;
    logic              w_push;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_head_nxt;

    // Next-state: accept a push when room exists or a pop frees a slot this edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
        w_pop        = r_valid && i_ready;
        w_push       = i_push && ((r_count != DEPTH_C) || w_pop);
        w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
        w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_head_nxt   = '0;
        if (w_count_nxt != '0) begin
            // The new head is the word being written only when the FIFO drains to it this edge.
            if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
                w_head_nxt = i_push_data;
            end else begin
                w_head_nxt = r_mem[w_rd_ptr_nxt];
            end
        end
    end

    // Storage array: written on accepted pushes only.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; r_count and the zeroed head gate every read of it.
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_valid  <= (w_count_nxt != '0);
            r_head   <= w_head_nxt;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_head;
    assign o_full  = (r_count == DEPTH_C);

endmodule

// File: rtl/sync_edge_event.sv
// Glitch filter, edge pulses, timestamped event log and rising-edge counter
// for an already-synchronized level in the dst_clk domain.
module sync_edge_event
    import cdc_pkg::*;
#(
    parameter int FILTER_LEN = 3,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             dst_clk,
    input  logic             rst,
    input  logic             sync_data,
    output logic             filt_data,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_rising,
    output logic [TS_W-1:0]  evt_ts,
    output logic [CNT_W-1:0] rise_count,
    output logic             overflow,
    input  logic             clr_overflow
);
    localparam int               EVT_W   = evt_width(TS_W);
    localparam logic [7:0]       M_LAST  = 8'(FILTER_LEN - 1);
    localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_filt;
    logic [7:0]       r_m;
    logic             r_rise;
    logic             r_fall;
    logic [TS_W-1:0]  r_ts;
    logic [CNT_W-1:0] r_rise_cnt;
    logic             r_ovf;

    logic             w_mismatch;
    logic             w_accept;
    logic             w_pop;
    logic             w_full;
    logic             w_drop;
    logic [EVT_W-1:0] w_evt;
    logic [EVT_W-1:0] w_head;

    // The FILTER_LEN-th consecutive mismatching sample is the accepting edge.
    assign w_mismatch = (sync_data != r_filt);
    assign w_accept   = w_mismatch && (r_m == M_LAST);
    assign w_evt      = {sync_data, r_ts};
    assign w_pop      = evt_valid && evt_ready;
    assign w_drop     = w_accept && w_full && !w_pop;

    // Consecutive-mismatch filter and one-cycle edge pulses.
    always_ff @(posedge dst_clk) begin
        if (rst) begin
            r_filt <= 1'b0;
            r_m    <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept && sync_data;
            r_fall <= w_accept && !sync_data;
            if (w_accept) begin
                r_filt <= sync_data;
                r_m    <= '0;
            end else if (w_mismatch) begin
                r_m <= r_m + 8'd1;
            end else begin
                r_m <= '0;
            end
        end
    end

    // Free-running timestamp, wrapping at 2^TS_W.
    always_ff @(posedge dst_clk) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_ONE;
        end
    end

    // Saturating count of accepted rising edges, dropped events included.
    always_ff @(posedge dst_clk) begin
        if (rst) begin
            r_rise_cnt <= '0;
        end else if (w_accept && sync_data && (r_rise_cnt != CNT_MAX)) begin
            r_rise_cnt <= r_rise_cnt + CNT_ONE;
        end
    end

    // Sticky overflow; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge dst_clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_overflow) begin
            r_ovf <= 1'b0;
        end
    end

    evt_fifo #(
        .DATA_W (EVT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk         (dst_clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_push_data (w_evt),
        .i_ready     (evt_ready),
        .o_valid     (evt_valid),
        .o_data      (w_head),
        .o_full      (w_full)
    );

    assign filt_data  = r_filt;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign evt_rising = w_head[EVT_W-1];
    assign evt_ts     = w_head[TS_W-1:0];
    assign rise_count = r_rise_cnt;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_sync_edge_event.sv
// Randomized and directed bench for sync_edge_event with a sample-history
// reference model and an event scoreboard.
module tb_sync_edge_event;
    localparam int FL    = 3;
    localparam int TSW   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic           dst_clk      = 1'b0;
    logic           rst          = 1'b1;
    logic           sync_data    = 1'b0;
    logic           evt_ready    = 1'b0;
    logic           clr_overflow = 1'b0;
    logic           filt_data;
    logic           rise_pulse;
    logic           fall_pulse;
    logic           evt_valid;
    logic           evt_rising;
    logic [TSW-1:0] evt_ts;
    logic [CW-1:0]  rise_count;
    logic           overflow;

    sync_edge_event #(
        .FILTER_LEN (FL),
        .TS_W       (TSW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .dst_clk      (dst_clk),
        .rst          (rst),
        .sync_data    (sync_data),
        .filt_data    (filt_data),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_rising   (evt_rising),
        .evt_ts       (evt_ts),
        .rise_count   (rise_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 dst_clk = ~dst_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        bit rising;
        int ts;
    } ev_t;

    ev_t exp_q[$];
    bit  hist[$];
    bit  m_level = 1'b0;
    bit  m_rp    = 1'b0;
    bit  m_fp    = 1'b0;
    bit  m_ovf   = 1'b0;
    int  m_rc    = 0;
    int  m_ts    = 0;
    int  m_occ   = 0;

    // Model: a change is accepted once the last FL samples all equal a value
    // different from the current filtered level.
    initial forever begin
        bit acc;
        bit pop;
        bit drop;
        bit same;
        @(posedge dst_clk);
        if (rst) begin
            hist.delete();
            exp_q.delete();
            m_level = 1'b0;
            m_rp    = 1'b0;
            m_fp    = 1'b0;
            m_ovf   = 1'b0;
            m_rc    = 0;
            m_ts    = 0;
            m_occ   = 0;
        end else begin
            hist.push_back(sync_data);
            if (hist.size() > FL) void'(hist.pop_front());
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != sync_data) same = 1'b0;
            acc  = (hist.size() == FL) && same && (sync_data != m_level);
            pop  = (m_occ > 0) && evt_ready;
            drop = 1'b0;
            m_rp = acc && sync_data;
            m_fp = acc && !sync_data;
            if (acc) begin
                if (sync_data && m_rc < (1 << CW) - 1) m_rc++;
                if (m_occ < DEPTH || pop) begin
                    exp_q.push_back('{rising: sync_data, ts: m_ts});
                    m_occ++;
                end else begin
                    drop = 1'b1;
                end
                m_level = sync_data;
            end
            if (pop) m_occ--;
            if (drop) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
            m_ts = (m_ts + 1) % (1 << TSW);
        end
    end

    // Monitor: compares every output mid-cycle and retires scoreboard entries on handshakes.
    initial forever begin
        @(negedge dst_clk);
        check("filt_data",  32'(filt_data),  32'(m_level));
        check("rise_pulse", 32'(rise_pulse), 32'(m_rp));
        check("fall_pulse", 32'(fall_pulse), 32'(m_fp));
        check("rise_count", 32'(rise_count), 32'(m_rc));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("evt_valid",  32'(evt_valid),  32'(m_occ > 0));
        if (evt_valid) begin
            if (exp_q.size() > 0) begin
                check("evt_rising", 32'(evt_rising), 32'(exp_q[0].rising));
                check("evt_ts",     32'(evt_ts),     32'(exp_q[0].ts));
                if (evt_ready && !rst) void'(exp_q.pop_front());
            end
        end else begin
            check("idle_rising", 32'(evt_rising), 32'd0);
            check("idle_ts",     32'(evt_ts),     32'd0);
        end
    end

    // Advance n edges; inputs change 2 time units after each edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge dst_clk);
            #2;
        end
    endtask

    initial begin
        int hold;
        // Reset held 3 cycles with sync_data high
        rst = 1'b1; sync_data = 1'b1; evt_ready = 1'b0; clr_overflow = 1'b0;
        tick(3);
        check("rst_filt",  32'(filt_data),  32'd0);
        check("rst_rise",  32'(rise_pulse), 32'd0);
        check("rst_fall",  32'(fall_pulse), 32'd0);
        check("rst_valid", 32'(evt_valid),  32'd0);
        check("rst_ts",    32'(evt_ts),     32'd0);
        check("rst_cnt",   32'(rise_count), 32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);
        rst = 1'b0;
        tick(2);
        check("early_filt", 32'(filt_data), 32'd0);
        tick(1);
        check("first_filt",   32'(filt_data),  32'd1);
        check("first_pulse",  32'(rise_pulse), 32'd1);
        check("first_valid",  32'(evt_valid),  32'd1);
        check("first_rising", 32'(evt_rising), 32'd1);
        check("first_ts",     32'(evt_ts),     32'd2);
        tick(1);
        check("pulse_width", 32'(rise_pulse), 32'd0);

        // Glitch of two samples is rejected
        rst = 1'b1; sync_data = 1'b0;
        tick(2);
        rst = 1'b0; sync_data = 1'b1;
        tick(2);
        sync_data = 1'b0;
        tick(5);
        check("glitch_filt",  32'(filt_data),  32'd0);
        check("glitch_cnt",   32'(rise_count), 32'd0);
        check("glitch_valid", 32'(evt_valid),  32'd0);

        // Rise then fall ten cycles apart, consumer always ready
        evt_ready = 1'b1; sync_data = 1'b1;
        tick(10);
        sync_data = 1'b0;
        tick(10);
        check("toggle_cnt",   32'(rise_count), 32'd1);
        check("toggle_valid", 32'(evt_valid),  32'd0);

        // Five accepted edges into a stalled FIFO of four
        rst = 1'b1;
        tick(1);
        rst = 1'b0; evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sync_data = ~sync_data;
            tick(4);
        end
        check("ovf_set",   32'(overflow),  32'd1);
        check("ovf_valid", 32'(evt_valid), 32'd1);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        evt_ready = 1'b1;
        tick(6);
        check("ovf_drained", 32'(evt_valid), 32'd0);

        // Fill, then land an accepting edge on the same edge as a pop
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sync_data = ~sync_data;
            tick(4);
        end
        sync_data = ~sync_data;
        tick(2);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("pp_ovf", 32'(overflow), 32'd0);
        tick(2);
        evt_ready = 1'b1;
        tick(3);
        check("pp_left_one", 32'(evt_valid), 32'd1);
        tick(1);
        check("pp_empty", 32'(evt_valid), 32'd0);

        // Five rising edges saturate a 2-bit counter at 3
        rst = 1'b1; sync_data = 1'b0;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sync_data = ~sync_data;
            tick(4);
        end
        check("sat_cnt", 32'(rise_count), 32'd3);

        // Randomized traffic with varying consumer pressure
        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                sync_data = 1'($urandom_range(0, 1));
                hold      = int'($urandom_range(1, 6));
            end
            hold--;
            evt_ready    = (c < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        rst = 1'b0; clr_overflow = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
